wallace_dot_acc: RTL and testbench

//  Sits directly downstream of the 16x16 pipelined Wallace multiplier. It consumes the multiplier's p/done

---
 rtl/wallace_dot_acc.sv | 174 +++++++++++++++++
 tb/tb_wallace_dot_acc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_dot_acc.sv
// wallace_dot_acc
//   Dot-product accumulator placed directly behind the 16x16 pipelined Wallace
//   multiplier. The multiplier cannot stall, so every issued op is tagged and
//   the tag travels through a LATENCY-deep delay line. When it comes out, it
//   lines up with the product of that op. Products of one vector are summed.
//   On the last element the sum and the element count go into a small result
//   FIFO. op_ready is a credit: it is high only while the FIFO still has room
//   for every last-element tag that is already in flight.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   op_valid_i   issuer presents a/b to the multiplier this cycle
//   op_last_i    qualifies op_valid_i: final element of the vector
//   op_ready_o   credit available; ops issued while low are not tagged
//   mul_p_i      multiplier product
//   mul_done_i   multiplier pipeline-filled flag
//   res_valid_o  FIFO head holds a completed dot product
//   res_ready_i  consumer takes the head when res_valid_o & res_ready_i
//   res_data_o   dot product (mod 2^ACC_W)
//   res_count_o  element count of that vector (saturating)
//   acc_ovf_o    sticky accumulator carry-out flag
module wallace_dot_acc #(
  parameter int LATENCY    = 6,
  parameter int ACC_W      = 40,
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             op_valid_i,
  input  logic             op_last_i,
  output logic             op_ready_o,
  input  logic [31:0]      mul_p_i,
  input  logic             mul_done_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_data_o,
  output logic [CNT_W-1:0] res_count_o,
  output logic             acc_ovf_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = PTR_W + 1;

  typedef struct packed {
    logic [ACC_W-1:0] data;
    logic [CNT_W-1:0] cnt;
  } res_t;

  // ---------------------------------------------------------------- tagging
  logic               accepted;
  logic [LATENCY-1:0] vld_pipe_q, lst_pipe_q;
  logic               tag_v, tag_last;

  assign accepted = op_valid_i & op_ready_o;
  assign tag_v    = vld_pipe_q[LATENCY-1];
  assign tag_last = lst_pipe_q[LATENCY-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe_q <= '0;
      lst_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[LATENCY-2:0], accepted};
      lst_pipe_q <= {lst_pipe_q[LATENCY-2:0], accepted & op_last_i};
    end
  end

  // ------------------------------------------------------------ accumulator
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             ovf_q, ovf_d;
  logic [31:0]      prod;
  logic [ACC_W:0]   sum;
  logic             push;

  // A tagged slot without mul_done still counts as an element and adds zero.
  assign prod     = mul_done_i ? mul_p_i : 32'd0;
  assign sum      = {1'b0, acc_q} + {{(ACC_W+1-32){1'b0}}, prod};
  assign cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign push     = tag_v & tag_last;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (tag_v) begin
      ovf_d = ovf_q | sum[ACC_W];
      if (tag_last) begin
        // The finished sum goes to the FIFO. The next vector starts from zero
        // on the same edge, so no bubble is needed between vectors.
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum[ACC_W-1:0];
        cnt_d = cnt_next;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_ovf_o = ovf_q;

  // ------------------------------------------------------------ result FIFO
  res_t             mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_q, rd_q;
  logic             empty, full, pop;

  assign empty       = (wr_q == rd_q);
  assign full        = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                       (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign res_valid_o = ~empty;
  assign pop         = res_valid_o & res_ready_i;
  assign res_data_o  = mem_q[rd_q[PTR_W-1:0]].data;
  assign res_count_o = mem_q[rd_q[PTR_W-1:0]].cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[PTR_W-1:0]] <= '{data: sum[ACC_W-1:0], cnt: cnt_next};
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  // ----------------------------------------------------------------- credits
  // reserved = FIFO occupancy + last-tags still in the delay line. It goes up
  // when a last is accepted and down when an entry is popped. Because
  // op_ready_o gates every op, not only lasts, a vector is never split.
  logic [CRD_W-1:0] reserved_q, reserved_d;
  logic             take;

  assign take = accepted & op_last_i;

  always_comb begin
    reserved_d = reserved_q;
    case ({take, pop})
      2'b10:   reserved_d = reserved_q + 1'b1;
      2'b01:   reserved_d = reserved_q - 1'b1;
      default: reserved_d = reserved_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) reserved_q <= '0;
    else         reserved_q <= reserved_d;
  end

  assign op_ready_o = (reserved_q < CRD_W'(FIFO_DEPTH));

`ifndef SYNTHESIS
  // Credits make a push into a full FIFO without a matching pop unreachable.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && full && !pop));
`endif

endmodule

// File: tb/tb_wallace_dot_acc.sv
module tb_wallace_dot_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid, op_last, op_ready;
  logic [15:0] op_a, op_b;
  logic [31:0] mul_p;
  logic        mul_done;
  logic        res_valid, res_ready;
  logic [39:0] res_data;
  logic [7:0]  res_count;
  logic        acc_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wallace_dot_acc dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .op_valid_i (op_valid),
    .op_last_i  (op_last),
    .op_ready_o (op_ready),
    .mul_p_i    (mul_p),
    .mul_done_i (mul_done),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_data_o (res_data),
    .res_count_o(res_count),
    .acc_ovf_o  (acc_ovf)
  );

  // Behavioural stand-in for the 6-stage multiplier. It free-runs and ignores
  // this block's reset, so stale products keep flowing across a reset.
  logic [31:0] mp [6];
  int          done_cnt = 0;
  always @(posedge clk) begin
    mp[0] <= {16'b0, op_a} * {16'b0, op_b};
    for (int i = 1; i < 6; i++) mp[i] <= mp[i-1];
    if (done_cnt < 6) done_cnt <= done_cnt + 1;
  end
  assign mul_p    = mp[5];
  assign mul_done = (done_cnt >= 6);

  // Independent credit model: last ops taken minus results popped.
  int tb_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_res <= 0;
    else tb_res <= tb_res + int'(op_valid && op_ready && op_last)
                          - int'(res_valid && res_ready);
  end

  typedef struct {
    logic [39:0] d;
    logic [7:0]  c;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [39:0] d;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic last);
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_last  = last;
    step();
    op_valid = 1'b0;
    op_last  = 1'b0;
  endtask

  // Waits for res_valid (bounded) and checks the head. The step afterwards
  // pops it when res_ready is high. n returns the number of cycles waited.
  task automatic expect_res(input string nm, input logic [39:0] d, input logic [7:0] c,
                            output int n);
    n = 0;
    while (!res_valid && n < 400) begin
      step();
      n++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: res_valid never rose within %0d cycles", nm, n);
    end else begin
      chk({nm, ".data"}, res_data, d);
      chk({nm, ".count"}, res_count, c);
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int   n;

    tbl[0] = '{a: 16'd3,      b: 16'd4,      d: 40'd12};
    tbl[1] = '{a: 16'd0,      b: 16'd0,      d: 40'd0};
    tbl[2] = '{a: 16'hFFFF,   b: 16'hFFFF,   d: 40'hFFFE0001};
    tbl[3] = '{a: 16'd1,      b: 16'hFFFF,   d: 40'h0000FFFF};
    tbl[4] = '{a: 16'h1234,   b: 16'h0010,   d: 40'h0000012340};

    rst_n = 1'b0; op_valid = 1'b0; op_last = 1'b0;
    op_a = '0; op_b = '0; res_ready = 1'b1;
    repeat (3) step();
    chk("reset.op_ready", op_ready, 1);
    chk("reset.res_valid", res_valid, 0);
    chk("reset.res_data", res_data, 0);
    chk("reset.res_count", res_count, 0);
    chk("reset.acc_ovf", acc_ovf, 0);
    rst_n = 1'b1;
    step();

    // Single-element vectors. The first one also checks latency: the op is
    // issued in cycle t and res_valid must rise in cycle t+7.
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i].a, tbl[i].b, 1'b1);
      expect_res($sformatf("single[%0d]", i), tbl[i].d, 8'd1, n);
      if (i == 0) chk("single.latency", n, 6);
    end

    // Back-to-back vectors, no bubble.
    issue(16'd1, 16'd1, 1'b0);
    issue(16'd2, 16'd2, 1'b0);
    issue(16'd3, 16'd3, 1'b0);
    issue(16'd4, 16'd4, 1'b1);
    issue(16'd5, 16'd5, 1'b1);
    expect_res("vec.first", 40'd30, 8'd4, n);
    expect_res("vec.second", 40'd25, 8'd1, n);
    chk("vec.consecutive", n, 0);

    // Backpressure: four credits, the fifth last is refused.
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp.op_ready[%0d]", k), op_ready, (k < 4) ? 1 : 0);
      issue(16'(k + 1), 16'd10, 1'b1);
    end
    repeat (10) step();
    chk("bp.res_valid", res_valid, 1);
    chk("bp.head", res_data, 40'd10);
    repeat (2) step();
    chk("bp.hold", res_data, 40'd10);
    chk("bp.op_ready_full", op_ready, 0);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++)
      expect_res($sformatf("bp.pop[%0d]", k), 40'(10 * (k + 1)), 8'd1, n);
    repeat (10) step();
    chk("bp.no_fifth", res_valid, 0);
    chk("bp.op_ready_back", op_ready, 1);

    // Overflow and count saturation.
    chk("ovf.before", acc_ovf, 0);
    for (int k = 0; k < 256; k++) issue(16'hFFFF, 16'hFFFF, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    expect_res("ovf", 40'h00FDFE0101, 8'd255, n);
    chk("ovf.sticky", acc_ovf, 1);

    // Gaps between elements, a filled FIFO, and a consumer that stalls.
    fork
      begin
        for (int v = 0; v < 8; v++) begin
          logic [39:0] s;
          int          len;
          int          w;
          logic [15:0] a, b;
          s   = '0;
          len = v % 3 + 1;
          for (int e = 0; e < len; e++) begin
            repeat ((v + e) % 4) step();
            w = 0;
            while (!op_ready && w < 300) begin
              step();
              w++;
            end
            if (!op_ready) begin
              checks++;
              errors++;
              $display("FAIL gaps.issue: op_ready stuck low, vector %0d", v);
            end
            a = 16'(v * 7 + e + 1);
            b = 16'(e + 3);
            s = s + 40'(a * b);
            if (e == len - 1) exp_q.push_back('{d: s, c: 8'(len)});
            issue(a, b, e == len - 1);
          end
        end
      end
      begin
        int   cyc, got;
        exp_t ex;
        cyc = 0;
        got = 0;
        while (got < 8 && cyc < 3000) begin
          res_ready = (cyc < 40) ? 1'b0 : (cyc % 3 != 0);
          chk("gaps.credit", op_ready, (tb_res < 4) ? 1 : 0);
          if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL gaps.unexpected: got %0h, expected no result", res_data);
            end else begin
              ex = exp_q.pop_front();
              chk($sformatf("gaps.data[%0d]", got), res_data, ex.d);
              chk($sformatf("gaps.count[%0d]", got), res_count, ex.c);
            end
            got++;
          end
          step();
          cyc++;
        end
        if (got < 8) begin
          checks++;
          errors++;
          $display("FAIL gaps.timeout: got %0d results, expected 8", got);
        end
        res_ready = 1'b1;
      end
    join

    // Reset in the middle of a vector.
    repeat (10) step();
    issue(16'd5, 16'd5, 1'b0);
    issue(16'd6, 16'd6, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst.acc_ovf", acc_ovf, 0);
    chk("rst.op_ready", op_ready, 1);
    chk("rst.res_data", res_data, 0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("rst.res_valid[%0d]", k), res_valid, 0);
      step();
    end
    issue(16'd2, 16'd3, 1'b1);
    expect_res("rst.next", 40'd6, 8'd1, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
